// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch PC unit: default PC type and next-PC source select.
package if_pkg;

  localparam int PC_W_DEF = 10;

  typedef logic [PC_W_DEF-1:0] pc_t;

  typedef enum logic [2:0] {
    NPC_START,
    NPC_HOLD,
    NPC_RET,
    NPC_CALL,
    NPC_ABS,
    NPC_REL,
    NPC_INC
  } npc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          udf
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, wp_m1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          wr_en;

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    wr_en = 1'b0;
    wp_m1 = wp_q - PW'(1);
    ovf   = push & full_q;
    udf   = pop & empty_q;
    if (clear) begin
      cnt_d = '0;
    end else if (pop && !empty_q) begin
      wp_d  = wp_m1;
      cnt_d = cnt_q - CW'(1);
    end else if (push) begin
      // The write slot when full is exactly the oldest entry, so the count saturates.
      wr_en = 1'b1;
      wp_d  = wp_q + PW'(1);
      if (!full_q) cnt_d = cnt_q + CW'(1);
    end
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= push_data;
  end

  assign top   = mem_q[wp_m1];
  assign count = cnt_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/inst_fetch_ras.sv
// Program counter with priority next-PC select; return-address stack present only when IF_RAS_EN is defined.
module inst_fetch_ras
  import if_pkg::*;
#(
  parameter int              PC_W       = 10,
  parameter int              RAS_DEPTH  = 4,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic            Stall,
  input  logic            BranchAbs,
  input  logic            BranchRelEn,
  input  logic            ALU_flag,
  input  logic            Call,
  input  logic            Ret,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] ProgCtr,
  output logic            RasEmpty,
  output logic            RasFull,
  output logic [1:0]      RasErr
);

  logic [PC_W-1:0] pc_q, pc_d, pc_inc, ret_pc;
  npc_sel_e        sel;

  always_comb begin
    sel = NPC_INC;
    if (Start)                      sel = NPC_START;
    else if (Stall)                 sel = NPC_HOLD;
    else if (Ret)                   sel = NPC_RET;
    else if (Call)                  sel = NPC_CALL;
    else if (BranchAbs)             sel = NPC_ABS;
    else if (BranchRelEn && ALU_flag) sel = NPC_REL;
  end

  assign pc_inc = pc_q + PC_W'(1);

`ifdef IF_RAS_EN
  logic [PC_W-1:0]              ras_top;
  logic [$clog2(RAS_DEPTH):0]   ras_count;
  logic                         ras_full, ras_empty, ras_ovf, ras_udf;
  logic [1:0]                   err_q, err_d;

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (sel == NPC_CALL),
    .pop       (sel == NPC_RET),
    .clear     (sel == NPC_START),
    .push_data (pc_inc),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty),
    .ovf       (ras_ovf),
    .udf       (ras_udf)
  );

  // Errors are sticky and survive Start; only reset clears them.
  assign err_d  = err_q | {ras_ovf, ras_udf};
  assign ret_pc = ras_empty ? pc_inc : ras_top;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) err_q <= '0;
    else          err_q <= err_d;
  end

  assign RasEmpty = ras_empty;
  assign RasFull  = ras_full;
  assign RasErr   = err_q;
`else
  assign ret_pc   = pc_inc;
  assign RasEmpty = 1'b1;
  assign RasFull  = 1'b0;
  assign RasErr   = 2'b00;
`endif

  always_comb begin
    pc_d = pc_inc;
    case (sel)
      NPC_START:         pc_d = START_ADDR;
      NPC_HOLD:          pc_d = pc_q;
      NPC_RET:           pc_d = ret_pc;
      NPC_CALL, NPC_ABS: pc_d = Target;
      NPC_REL:           pc_d = pc_q + Target;
      default:           pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) pc_q <= '0;
    else          pc_q <= pc_d;
  end

  assign ProgCtr = pc_q;

endmodule

// File: tb/tb_inst_fetch_ras.sv
// Scoreboard bench for inst_fetch_ras: reference model predicts state after each edge, monitor compares.
module tb_inst_fetch_ras;

  localparam int              PC_W  = 10;
  localparam int              DEPTH = 4;
  localparam int              MASK  = (1 << PC_W) - 1;
  localparam logic [PC_W-1:0] START = '0;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic            Start, Stall, BranchAbs, BranchRelEn, ALU_flag, Call, Ret;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] ProgCtr;
  logic            RasEmpty, RasFull;
  logic [1:0]      RasErr;

  always #5 Clk = ~Clk;

  inst_fetch_ras #(
    .PC_W       (PC_W),
    .RAS_DEPTH  (DEPTH),
    .START_ADDR (START)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .Stall       (Stall),
    .BranchAbs   (BranchAbs),
    .BranchRelEn (BranchRelEn),
    .ALU_flag    (ALU_flag),
    .Call        (Call),
    .Ret         (Ret),
    .Target      (Target),
    .ProgCtr     (ProgCtr),
    .RasEmpty    (RasEmpty),
    .RasFull     (RasFull),
    .RasErr      (RasErr)
  );

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            empty;
    logic            full;
    logic [1:0]      err;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         m_pc;
  int         m_stk[$];
  logic [1:0] m_err;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pc = 0;
    m_stk.delete();
    m_err = 2'b00;
  endfunction

  task automatic apply(input logic st, input logic sl, input logic ba, input logic br,
                       input logic fl, input logic ca, input logic re, input logic [PC_W-1:0] tg);
    exp_t e;
    Start = st; Stall = sl; BranchAbs = ba; BranchRelEn = br;
    ALU_flag = fl; Call = ca; Ret = re; Target = tg;
    if (st) begin
      m_pc = int'(START);
      m_stk.delete();
    end else if (sl) begin
      // frozen
    end else if (re) begin
`ifdef IF_RAS_EN
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin
        m_pc = (m_pc + 1) & MASK;
        m_err[0] = 1'b1;
      end
`else
      m_pc = (m_pc + 1) & MASK;
`endif
    end else if (ca) begin
`ifdef IF_RAS_EN
      m_stk.push_back((m_pc + 1) & MASK);
      if (m_stk.size() > DEPTH) begin
        void'(m_stk.pop_front());
        m_err[1] = 1'b1;
      end
`endif
      m_pc = int'(tg);
    end else if (ba) begin
      m_pc = int'(tg);
    end else if (br && fl) begin
      m_pc = (m_pc + int'(tg)) & MASK;
    end else begin
      m_pc = (m_pc + 1) & MASK;
    end
    e.pc = m_pc[PC_W-1:0];
`ifdef IF_RAS_EN
    e.empty = (m_stk.size() == 0);
    e.full  = (m_stk.size() == DEPTH);
    e.err   = m_err;
`else
    e.empty = 1'b1;
    e.full  = 1'b0;
    e.err   = 2'b00;
`endif
    exp_q.push_back(e);
  endtask

  task automatic step(input logic st, input logic sl, input logic ba, input logic br,
                      input logic fl, input logic ca, input logic re, input logic [PC_W-1:0] tg);
    @(negedge Clk);
    apply(st, sl, ba, br, fl, ca, re, tg);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic idle_to(input int a);
    for (int i = 0; i < 1100 && m_pc != a; i++) idle();
  endtask

  task automatic check_reset_now(input string tag);
    check({tag, "_pc"},    ProgCtr,  0);
    check({tag, "_empty"}, RasEmpty, 1);
    check({tag, "_full"},  RasFull,  0);
    check({tag, "_err"},   RasErr,   0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (Reset_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",    ProgCtr,  e.pc);
        check("empty", RasEmpty, e.empty);
        check("full",  RasFull,  e.full);
        check("err",   RasErr,   e.err);
      end
    end
  end

  initial begin : stim
    Reset_n = 1'b0;
    Start = 0; Stall = 0; BranchAbs = 0; BranchRelEn = 0;
    ALU_flag = 0; Call = 0; Ret = 0; Target = '0;
    model_reset();
    #1;
    check_reset_now("rst");
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, '0);
    repeat (3) idle();

    idle_to(12);
    step(0, 0, 1, 0, 0, 0, 0, '0);
    step(0, 0, 1, 0, 0, 0, 0, '0);
    idle();

    idle_to(20);
    step(0, 0, 0, 1, 1, 0, 0, 10'h3FC);
    step(0, 0, 0, 1, 0, 0, 0, 10'h3FC);
    step(0, 0, 0, 1, 1, 0, 0, 10'h3FF);

    step(1, 0, 0, 0, 0, 0, 0, '0);
    idle_to(5);
    step(0, 0, 0, 0, 0, 1, 0, 10'd100);
    idle_to(103);
    step(0, 0, 0, 0, 0, 0, 1, '0);
    idle();

    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0, PC_W'(200 + 40 * i));
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1, '0);

    step(0, 0, 0, 0, 0, 1, 0, 10'd300);
    step(0, 0, 0, 0, 0, 1, 1, 10'd400);
    step(1, 0, 0, 0, 0, 0, 0, '0);

    idle_to(7);
    step(0, 1, 0, 0, 0, 1, 0, 10'd50);
    step(0, 1, 0, 0, 0, 0, 1, '0);
    idle();
    step(0, 0, 1, 0, 0, 0, 0, 10'h3FF);
    idle();
    idle();

    for (int i = 0; i < 400; i++) begin
      if (i == 150) begin
        @(negedge Clk);
        Reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_now("midrst");
        #2;
        Reset_n = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, '0);
      end else begin
        step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
             $urandom_range(0, 5) == 0, PC_W'($urandom & MASK));
      end
    end

    @(negedge Clk);
    apply(0, 0, 0, 0, 0, 0, 0, '0);
    repeat (3) @(posedge Clk);
    #2;
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
